// File: rtl/ex_div_unit_pkg.sv
// Shared types and constants for the EX-stage restoring divider.
// Build with DIV_ZERO_FAST_EN defined to finish divide-by-zero in one cycle.
package ex_div_unit_pkg;

    localparam int unsigned DIV_W     = 32;
    localparam int unsigned DIV_CNT_W = 5;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Magnitude of a two's complement value when signed, raw value otherwise.
    function automatic logic [DIV_W-1:0] div_abs(input logic [DIV_W-1:0] v, input logic is_signed);
        return (is_signed & v[DIV_W-1]) ? DIV_W'(~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/ex_div_unit_div_step.sv
// One restoring-division iteration: shift {rem, dvd} left, trial-subtract, restore or keep.
module div_step
    import ex_div_unit_pkg::*;
(
    input  logic [2*DIV_W-1:0] pair_i,
    input  logic [DIV_W-1:0]   divisor_i,
    output logic [2*DIV_W-1:0] pair_o,
    output logic               q_bit_o
);

    logic [2*DIV_W:0] shifted;
    logic [DIV_W:0]   trial;

    always_comb begin
        shifted = {pair_i, 1'b0};
        // 33-bit trial so the bit shifted out of the remainder is kept
        trial   = shifted[2*DIV_W:DIV_W] - {1'b0, divisor_i};
        q_bit_o = ~trial[DIV_W];
        pair_o  = {(q_bit_o ? trial[DIV_W-1:0] : shifted[2*DIV_W-1:DIV_W]),
                   shifted[DIV_W-1:1], q_bit_o};
    end

endmodule

// File: rtl/ex_div_unit.sv
// Multi-cycle MIPS DIV/DIVU unit: quotient on lo, remainder on hi, valid/ready handshake.
// Optional DIV_ZERO_FAST_EN skips the iterations when the divisor is zero.
module ex_div_unit
    import ex_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div_valid,
    output logic             div_ready,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cancel,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             busy
);

    div_state_e           state_q, state_d;
    logic [2*WIDTH-1:0]   pair_q, pair_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic                 q_neg_q, q_neg_d;
    logic                 r_neg_q, r_neg_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic                 div_ready_q, busy_q, result_valid_q;

    logic [2*WIDTH-1:0]   step_pair;
    logic                 step_q;
    logic [WIDTH-1:0]     quo, rem;
    logic                 finish;

    div_step u_div_step (
        .pair_i    (pair_q),
        .divisor_i (dvs_q),
        .pair_o    (step_pair),
        .q_bit_o   (step_q)
    );

    // Next-state, datapath and result sign correction
    always_comb begin
        state_d = state_q;
        pair_d  = pair_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        quo     = {step_pair[WIDTH-1:1], step_q};
        rem     = step_pair[2*WIDTH-1:WIDTH];
        finish  = 1'b0;

        case (state_q)
            DIV_IDLE: begin
                if (div_valid) begin
                    dvs_d   = div_abs(B, div_signed);
                    pair_d  = {WIDTH'(0), div_abs(A, div_signed)};
                    q_neg_d = div_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                    r_neg_d = div_signed & A[WIDTH-1];
                    cnt_d   = '0;
                    state_d = DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                pair_d = step_pair;
                cnt_d  = DIV_CNT_W'(cnt_q + 1'b1);
`ifdef DIV_ZERO_FAST_EN
                if (dvs_q == '0) begin
                    quo    = '1;
                    rem    = pair_q[WIDTH-1:0];
                    finish = 1'b1;
                end
`endif
                if (cnt_q == DIV_CNT_W'(WIDTH - 1)) begin
                    finish = 1'b1;
                end
                if (finish) begin
                    state_d = DIV_DONE;
                    lo_d    = q_neg_q ? WIDTH'(~quo + 1'b1) : quo;
                    hi_d    = r_neg_q ? WIDTH'(~rem + 1'b1) : rem;
                end
            end
            DIV_DONE: begin
                if (result_ready) begin
                    state_d = DIV_IDLE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase

        // Flush beats both acceptance and the result handshake
        if (cancel) begin
            state_d = DIV_IDLE;
            lo_d    = lo_q;
            hi_d    = hi_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= DIV_IDLE;
            pair_q         <= '0;
            dvs_q          <= '0;
            cnt_q          <= '0;
            q_neg_q        <= 1'b0;
            r_neg_q        <= 1'b0;
            lo_q           <= '0;
            hi_q           <= '0;
            div_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pair_q         <= pair_d;
            dvs_q          <= dvs_d;
            cnt_q          <= cnt_d;
            q_neg_q        <= q_neg_d;
            r_neg_q        <= r_neg_d;
            lo_q           <= lo_d;
            hi_q           <= hi_d;
            div_ready_q    <= (state_d == DIV_IDLE);
            busy_q         <= (state_d != DIV_IDLE);
            result_valid_q <= (state_d == DIV_DONE);
        end
    end

    assign div_ready    = div_ready_q;
    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign lo           = lo_q;
    assign hi           = hi_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// Scoreboard bench for ex_div_unit: results, latency, stall, cancel, reset and back-to-back.
module tb_ex_div_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        div_valid = 1'b0;
    logic        div_ready;
    logic        div_signed = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        cancel = 1'b0;
    logic        result_valid;
    logic        result_ready = 1'b0;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        busy;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    ex_div_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .div_valid    (div_valid),
        .div_ready    (div_ready),
        .div_signed   (div_signed),
        .A            (A),
        .B            (B),
        .cancel       (cancel),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .lo           (lo),
        .hi           (hi),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t   e;
        longint sa, sbv, q, r;
        if (b == 32'd0) begin
            e.lo = (s && a[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
            e.hi = a;
        end else if (s) begin
            sa   = longint'($signed(a));
            sbv  = longint'($signed(b));
            q    = sa / sbv;
            r    = sa % sbv;
            e.lo = q[31:0];
            e.hi = r[31:0];
        end else begin
            e.lo = a / b;
            e.hi = a % b;
        end
`ifdef DIV_ZERO_FAST_EN
        e.lat = (b == 32'd0) ? 1 : 32;
`else
        e.lat = 32;
`endif
        return e;
    endfunction

    // Present one request and wait for its acceptance edge
    task automatic start(input logic [31:0] a, input logic [31:0] b, input logic s);
        int n = 0;
        while (!div_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check_eq("ready_wait", 32'(div_ready), 32'd1);
        A = a; B = b; div_signed = s; div_valid = 1'b1;
        @(posedge clk); #1;
        div_valid = 1'b0;
        A = $urandom; B = $urandom; div_signed = $urandom_range(0, 1);
        sb.push_back(model(a, b, s));
        check_eq("busy_after_accept", 32'(busy), 32'd1);
    endtask

    // Wait for the result, optionally stall, then hand it off
    task automatic collect(input int hold, input bit b2b,
                           input logic [31:0] na, input logic [31:0] nb, input logic ns);
        exp_t e;
        int   n = 0;
        while (!result_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check_eq("result_valid_rise", 32'(result_valid), 32'd1);
        if (sb.size() == 0) begin
            check_eq("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check_eq("latency", 32'(n), 32'(e.lat));
        check_eq("lo", lo, e.lo);
        check_eq("hi", hi, e.hi);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_eq("hold_valid", 32'(result_valid), 32'd1);
            check_eq("hold_lo", lo, e.lo);
            check_eq("hold_hi", hi, e.hi);
        end
        result_ready = 1'b1;
        if (b2b) begin
            A = na; B = nb; div_signed = ns; div_valid = 1'b1;
        end
        @(posedge clk); #1;
        result_ready = 1'b0;
        check_eq("valid_after_handshake", 32'(result_valid), 32'd0);
        check_eq("ready_after_handshake", 32'(div_ready), 32'd1);
        if (b2b) begin
            check_eq("no_accept_in_handshake", 32'(busy), 32'd0);
            @(posedge clk); #1;
            div_valid = 1'b0;
            sb.push_back(model(na, nb, ns));
            check_eq("b2b_busy", 32'(busy), 32'd1);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_ready"}, 32'(div_ready), 32'd1);
        check_eq({pfx, "_busy"}, 32'(busy), 32'd0);
        check_eq({pfx, "_valid"}, 32'(result_valid), 32'd0);
        check_eq({pfx, "_lo"}, lo, 32'd0);
        check_eq({pfx, "_hi"}, hi, 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        resetn = 1'b1;
        @(posedge clk); #1;

        // Unsigned with a stalled consumer
        start(32'd100, 32'd7, 1'b0);
        collect(5, 1'b0, '0, '0, 1'b0);

        // Signed cases including overflow and divide-by-zero
        start(32'hFFFF_FFF9, 32'd2, 1'b1);
        collect(0, 1'b0, '0, '0, 1'b0);
        start(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        collect(0, 1'b0, '0, '0, 1'b0);
        start(32'h0000_1234, 32'd0, 1'b0);
        collect(1, 1'b0, '0, '0, 1'b0);
        start(32'hFFFF_FF00, 32'd0, 1'b1);
        collect(0, 1'b0, '0, '0, 1'b0);
        start(32'h0000_0005, 32'd0, 1'b1);
        collect(0, 1'b0, '0, '0, 1'b0);
        start(32'd7, 32'hFFFF_FFFE, 1'b1);
        collect(0, 1'b0, '0, '0, 1'b0);
        start(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        collect(0, 1'b0, '0, '0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            rs = 1'(i % 3 != 0);
            start(ra, rb, rs);
            collect(0, 1'b0, '0, '0, 1'b0);
        end

        // Cancel at iteration 10, then an immediate new request
        start(32'd1000, 32'd3, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        void'(sb.pop_back());
        check_eq("cancel_busy", 32'(busy), 32'd0);
        check_eq("cancel_valid", 32'(result_valid), 32'd0);
        check_eq("cancel_ready", 32'(div_ready), 32'd1);
        start(32'd1000, 32'd3, 1'b0);
        collect(0, 1'b0, '0, '0, 1'b0);

        // Asynchronous reset mid-division
        start(32'hDEAD_BEEF, 32'd17, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        void'(sb.pop_back());
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        // Back-to-back: new request held across the handshake
        start(32'd12345, 32'd10, 1'b0);
        collect(0, 1'b1, 32'hFFFF_F000, 32'd9, 1'b1);
        collect(0, 1'b0, '0, '0, 1'b0);

        check_eq("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
